addsub_pipe: RTL
================

ADDSUB_PIPE -- requirements
Module: addsub_pipe

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits; SHALL be a positive multiple of CHUNK.
REQ-002 Parameter CHUNK, default 4, bits added per pipeline stage; STAGES = WIDTH/CHUNK SHALL be at least 1.
REQ-003 The module SHALL have one clock; reset is asynchronous and active-low (ports clk, rst_n).
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  operand set presented.
REQ-007 in_ready  output  1  pipeline accepts the operand set this cycle.
REQ-008 a, b  input  WIDTH  operands.
REQ-009 ci  input  1  carry-in (add) or borrow-in (subtract).
REQ-010 sub  input  1  0 = add, 1 = subtract.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 s  output  WIDTH  result.
REQ-014 co  output  1  carry-out (add) / not-borrow (subtract).
REQ-015 ovf  output  1  two's-complement signed overflow.
REQ-016 zero  output  1  s equals 0.

Function
REQ-017 Add: {co, s} SHALL equal a + b + ci, computed at WIDTH+1 bits.
REQ-018 Subtract: {co, s} SHALL equal a + ~b + ~ci, i.e. s = a - b - ci and co = 0 on borrow.
REQ-019 ovf SHALL be 1 iff the effective operand MSBs (a, b or ~b) are equal and differ from s MSB.
REQ-020 Stage k (0..STAGES-1) SHALL add chunk k of both operands plus the registered carry from stage k-1 (stage 0 uses the effective carry-in).
REQ-021 Operand chunks above k SHALL travel unchanged with the item; result chunks below k SHALL be carried forward registered.
REQ-022 Latency SHALL be exactly STAGES cycles from acceptance (in_valid & in_ready) to out_valid with no backpressure.
REQ-023 Throughput SHALL be one operation per cycle while out_ready is held 1.
REQ-024 Each stage SHALL hold a valid bit; advance = ~out_valid | out_ready; all stages shift only when advance = 1.
REQ-025 in_ready SHALL equal advance, combinationally.
REQ-026 When advance = 0, every stage (data, carry, valid) SHALL hold its value; s/co/ovf/zero SHALL remain stable while out_valid & ~out_ready.
REQ-027 Bubbles (invalid stages) SHALL propagate and be overwritten; they SHALL never raise out_valid.
REQ-028 Simultaneous output pop and input push in one cycle SHALL both complete without loss or duplication.
REQ-029 sub and ci SHALL be sampled at acceptance and carried with the item; later changes SHALL not affect in-flight items.
REQ-030 s, co, ovf, zero SHALL be registered outputs of the last stage.

Reset
REQ-031 rst_n low SHALL asynchronously clear all stage valid bits, so out_valid = 0 immediately.
REQ-032 During reset, s = 0, co = 0, ovf = 0, zero = 0; in_ready reads 1.
REQ-033 Reset mid-operation SHALL discard all in-flight items; first acceptance after release yields first result STAGES cycles later.
REQ-034 Datapath registers other than valid bits and outputs MAY be non-reset.

Structure
REQ-035 Shared package/header SHALL hold the default WIDTH/CHUNK constants and the ADD/SUB mode encodings.
REQ-036 One sub-module addsub_stage (CHUNK-bit adder slice: chunk sum, carry-out, valid/enable registers) SHALL be instantiated STAGES times via generate.
REQ-037 Configuration WIDTH = CHUNK (STAGES = 1) SHALL elaborate and meet all requirements.

Verification (WIDTH=16, CHUNK=4, latency 4)
REQ-038 add a=0xFFFF, b=0x0001, ci=0 -> after 4 cycles s=0x0000, co=1, ovf=0, zero=1.
REQ-039 add a=0x7FFF, b=0x0001, ci=0 -> s=0x8000, co=0, ovf=1, zero=0; sub a=0x0005, b=0x0007, ci=0 -> s=0xFFFE, co=0, ovf=0.
REQ-040 Push 8 back-to-back random ops with out_ready=1 -> 8 results on 8 consecutive cycles, in order, matching reference model.
REQ-041 out_ready=0 for 6 cycles with pipeline full -> in_ready=0, outputs frozen, no loss; release -> results resume in order.
REQ-042 Assert rst_n=0 with 3 items in flight -> out_valid falls immediately, none of them ever appears after release.
REQ-043 Random add/sub/ci, random in_valid/out_ready, 10k ops, also WIDTH=8/CHUNK=8 and WIDTH=32/CHUNK=8 -> scoreboard match on s, co, ovf, zero.

Source files
------------

// File: rtl/addsub_pipe_pkg.sv
// Shared constants for the chunked add/subtract pipeline.
package addsub_pipe_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_CHUNK = 4;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

endpackage

// File: rtl/addsub_stage.sv
// One CHUNK-bit slice of the pipelined adder: adds chunk IDX and registers the item.
module addsub_stage
  import addsub_pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CHUNK = DEFAULT_CHUNK,
  parameter int IDX   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             prev_valid,
  input  logic [WIDTH-1:0] prev_a,
  input  logic [WIDTH-1:0] prev_b,
  input  logic [WIDTH-1:0] prev_s,
  input  logic             prev_c,
  output logic             valid,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s,
  output logic             c,
  output logic             ovf,
  output logic             zero
);

  logic [CHUNK:0]   sum;
  logic [WIDTH-1:0] s_next;

  // Lower result chunks ride along untouched; only chunk IDX is filled in here.
  always_comb begin
    sum    = {1'b0, prev_a[IDX*CHUNK +: CHUNK]} + {1'b0, prev_b[IDX*CHUNK +: CHUNK]}
           + {{CHUNK{1'b0}}, prev_c};
    s_next = prev_s;
    s_next[IDX*CHUNK +: CHUNK] = sum[CHUNK-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      s     <= '0;
      c     <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
    end else if (en) begin
      valid <= prev_valid;
      s     <= s_next;
      c     <= sum[CHUNK];
      ovf   <= (prev_a[WIDTH-1] == prev_b[WIDTH-1]) && (s_next[WIDTH-1] != prev_a[WIDTH-1]);
      zero  <= (s_next == '0);
    end
  end

  // Operands need no reset: they are only meaningful alongside a valid bit.
  always_ff @(posedge clk) begin
    if (en) begin
      a <= prev_a;
      b <= prev_b;
    end
  end

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined WIDTH-bit adder/subtractor, one CHUNK-bit slice per stage, valid/ready handshake.
module addsub_pipe
  import addsub_pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf,
  output logic             zero
);

  localparam int STAGES = WIDTH / CHUNK;

  if (CHUNK < 1 || WIDTH < CHUNK || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $error("addsub_pipe: WIDTH must be a positive multiple of CHUNK");
  end

  logic                          advance;
  logic                          is_sub;
  logic [STAGES:0]               valid_p;
  logic [STAGES:0]               c_p;
  logic [STAGES:0][WIDTH-1:0]    a_p;
  logic [STAGES:0][WIDTH-1:0]    b_p;
  logic [STAGES:0][WIDTH-1:0]    s_p;
  logic [STAGES-1:0]             ovf_p;
  logic [STAGES-1:0]             zero_p;

  // The whole pipe moves in lockstep, so a single stall signal freezes every stage.
  assign advance  = ~valid_p[STAGES] | out_ready;
  assign in_ready = advance;

  // Subtraction is folded into an add of ~b with inverted borrow at the entry point.
  assign is_sub     = (mode_e'(sub) == MODE_SUB);
  assign valid_p[0] = in_valid;
  assign a_p[0]     = a;
  assign b_p[0]     = is_sub ? ~b : b;
  assign c_p[0]     = is_sub ? ~ci : ci;
  assign s_p[0]     = '0;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    addsub_stage #(
      .WIDTH (WIDTH),
      .CHUNK (CHUNK),
      .IDX   (k)
    ) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (advance),
      .prev_valid (valid_p[k]),
      .prev_a     (a_p[k]),
      .prev_b     (b_p[k]),
      .prev_s     (s_p[k]),
      .prev_c     (c_p[k]),
      .valid      (valid_p[k+1]),
      .a          (a_p[k+1]),
      .b          (b_p[k+1]),
      .s          (s_p[k+1]),
      .c          (c_p[k+1]),
      .ovf        (ovf_p[k]),
      .zero       (zero_p[k])
    );
  end

  assign out_valid = valid_p[STAGES];
  assign s         = s_p[STAGES];
  assign co        = c_p[STAGES];
  assign ovf       = ovf_p[STAGES-1];
  assign zero      = zero_p[STAGES-1];

endmodule
